// File: rtl/stack_ctrl.sv
// Pointer/sequencing front-end for a 2R/1W data stack memory.
// One op per accepted request; SWAP spends a second cycle in SWAP2 for its extra write.
module stack_ctrl #(
    parameter int WIDTH = 6,
    parameter int SIZE  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [15:0]      din,
    output logic [15:0]      tos,
    output logic [15:0]      nos,
    output logic [WIDTH:0]   depth,
    output logic             empty,
    output logic             full,
    output logic             err_overflow,
    output logic             err_underflow,
    input  logic             err_clear,
    output logic [WIDTH-1:0] mem_dout_addr0,
    input  logic [15:0]      mem_dout0,
    output logic [WIDTH-1:0] mem_dout_addr1,
    input  logic [15:0]      mem_dout1,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_din_addr,
    output logic [15:0]      mem_din
);

    typedef enum logic {IDLE, SWAP2} state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_DUP  = 3'd3,
        OP_OVER = 3'd4,
        OP_SWAP = 3'd5,
        OP_REPL = 3'd6,
        OP_BIN  = 3'd7
    } op_t;

    localparam logic [WIDTH:0] SP_FULL = (WIDTH+1)'(SIZE);

    state_t           state;
    logic [WIDTH:0]   sp;
    logic [15:0]      swap_latch;

    logic             accept;
    logic             lt1;
    logic             lt2;
    logic             ovf;
    logic             udf;
    logic             we;
    logic             to_swap;
    logic [WIDTH-1:0] sp_lo;
    logic [WIDTH-1:0] waddr;
    logic [15:0]      wdata;
    logic [WIDTH:0]   sp_nx;

    assign sp_lo          = sp[WIDTH-1:0];
    assign mem_dout_addr0 = sp_lo - WIDTH'(1);
    assign mem_dout_addr1 = sp_lo - WIDTH'(2);

    assign depth    = sp;
    assign empty    = (sp == '0);
    assign full     = (sp == SP_FULL);
    assign lt1      = (sp < (WIDTH+1)'(1));
    assign lt2      = (sp < (WIDTH+1)'(2));
    assign op_ready = (state == IDLE);
    assign accept   = op_valid && op_ready;

    assign tos = lt1 ? '0 : mem_dout0;
    assign nos = lt2 ? '0 : mem_dout1;

    always_comb begin
        ovf     = 1'b0;
        udf     = 1'b0;
        we      = 1'b0;
        to_swap = 1'b0;
        waddr   = sp_lo;
        wdata   = din;
        sp_nx   = sp;
        if (state == SWAP2) begin
            we    = 1'b1;
            waddr = sp_lo - WIDTH'(2);
            wdata = swap_latch;
        end else if (accept) begin
            case (op_t'(op))
                OP_PUSH: begin
                    if (full) ovf = 1'b1;
                    else begin
                        we    = 1'b1;
                        sp_nx = sp + 1'b1;
                    end
                end
                OP_POP: begin
                    if (lt1) udf = 1'b1;
                    else     sp_nx = sp - 1'b1;
                end
                // Underflow is tested before overflow so DUP on empty reports underflow.
                OP_DUP: begin
                    if (lt1)       udf = 1'b1;
                    else if (full) ovf = 1'b1;
                    else begin
                        we    = 1'b1;
                        wdata = tos;
                        sp_nx = sp + 1'b1;
                    end
                end
                OP_OVER: begin
                    if (lt2)       udf = 1'b1;
                    else if (full) ovf = 1'b1;
                    else begin
                        we    = 1'b1;
                        wdata = nos;
                        sp_nx = sp + 1'b1;
                    end
                end
                OP_SWAP: begin
                    if (lt2) udf = 1'b1;
                    else begin
                        we      = 1'b1;
                        waddr   = sp_lo - WIDTH'(1);
                        wdata   = nos;
                        to_swap = 1'b1;
                    end
                end
                OP_REPL: begin
                    if (lt1) udf = 1'b1;
                    else begin
                        we    = 1'b1;
                        waddr = sp_lo - WIDTH'(1);
                    end
                end
                OP_BIN: begin
                    if (lt2) udf = 1'b1;
                    else begin
                        we    = 1'b1;
                        waddr = sp_lo - WIDTH'(2);
                        sp_nx = sp - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we       = we && rst_n;
    assign mem_din_addr = waddr;
    assign mem_din      = wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sp            <= '0;
            swap_latch    <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            sp <= sp_nx;
            if (state == SWAP2) begin
                state <= IDLE;
            end else if (to_swap) begin
                state      <= SWAP2;
                swap_latch <= tos;
            end
            // A fresh error outranks a simultaneous clear.
            if (ovf)            err_overflow <= 1'b1;
            else if (err_clear) err_overflow <= 1'b0;
            if (udf)            err_underflow <= 1'b1;
            else if (err_clear) err_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural memory and a write scoreboard.
module tb_stack_ctrl;

    localparam int WIDTH = 6;
    localparam int SIZE  = 64;

    logic             clk;
    logic             rst_n;
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op;
    logic [15:0]      din;
    logic [15:0]      tos;
    logic [15:0]      nos;
    logic [WIDTH:0]   depth;
    logic             empty;
    logic             full;
    logic             err_overflow;
    logic             err_underflow;
    logic             err_clear;
    logic [WIDTH-1:0] mem_dout_addr0;
    logic [15:0]      mem_dout0;
    logic [WIDTH-1:0] mem_dout_addr1;
    logic [15:0]      mem_dout1;
    logic             mem_we;
    logic [WIDTH-1:0] mem_din_addr;
    logic [15:0]      mem_din;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [15:0]      d;
    } wr_t;

    wr_t         wq[$];
    logic [15:0] mem [0:SIZE-1];
    int unsigned total  = 0;
    int unsigned passed = 0;

    stack_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op             (op),
        .din            (din),
        .tos            (tos),
        .nos            (nos),
        .depth          (depth),
        .empty          (empty),
        .full           (full),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow),
        .err_clear      (err_clear),
        .mem_dout_addr0 (mem_dout_addr0),
        .mem_dout0      (mem_dout0),
        .mem_dout_addr1 (mem_dout_addr1),
        .mem_dout1      (mem_dout1),
        .mem_we         (mem_we),
        .mem_din_addr   (mem_din_addr),
        .mem_din        (mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_din_addr] <= mem_din;
    assign mem_dout0 = mem[mem_dout_addr0];
    assign mem_dout1 = mem[mem_dout_addr1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexpected_write_addr", 32'(mem_din_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("write_addr", 32'(mem_din_addr), 32'(e.a));
                chk("write_data", 32'(mem_din), 32'(e.d));
            end
        end
    end

    task automatic exp_wr(input int a, input int d);
        wr_t e;
        e.a = WIDTH'(a);
        e.d = 16'(d);
        wq.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic issue(input int o, input int d);
        op_valid = 1'b1;
        op       = 3'(o);
        din      = 16'(d);
        @(posedge clk); #1;
        op_valid = 1'b0;
        op       = 3'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_mem_we", 32'(mem_we), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op        = 3'd0;
        din       = '0;
        err_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_depth", 32'(depth), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ready", 32'(op_ready), 1);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_flags", {30'd0, err_overflow, err_underflow}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // PUSH three values
        exp_wr(0, 16'h1111); issue(1, 16'h1111);
        exp_wr(1, 16'h2222); issue(1, 16'h2222);
        exp_wr(2, 16'h3333); issue(1, 16'h3333);
        chk("push3_depth", 32'(depth), 3);
        chk("push3_tos", 32'(tos), 32'h3333);
        chk("push3_nos", 32'(nos), 32'h2222);

        // SWAP from [1111,2222] with op_valid held
        issue(2, 0);
        chk("pop_depth", 32'(depth), 2);
        exp_wr(1, 16'h1111);
        exp_wr(0, 16'h2222);
        op_valid = 1'b1; op = 3'd5;
        #1;
        chk("swap_c1_ready", 32'(op_ready), 1);
        @(posedge clk); #1;
        chk("swap_c2_ready", 32'(op_ready), 0);
        chk("swap_c2_we", 32'(mem_we), 1);
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
        chk("swap_done_ready", 32'(op_ready), 1);
        chk("swap_tos", 32'(tos), 32'h1111);
        chk("swap_nos", 32'(nos), 32'h2222);
        chk("swap_depth", 32'(depth), 2);

        // Underflow and sticky-flag clearing
        issue(2, 0);
        issue(2, 0);
        op_valid = 1'b1; op = 3'd2;
        #1;
        chk("pop_empty_we", 32'(mem_we), 0);
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("pop_empty_udf", 32'(err_underflow), 1);
        chk("pop_empty_depth", 32'(depth), 0);
        chk("pop_empty_ovf", 32'(err_overflow), 0);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        chk("clear_udf", 32'(err_underflow), 0);
        err_clear = 1'b1;
        issue(2, 0);
        err_clear = 1'b0;
        chk("clear_vs_err", 32'(err_underflow), 1);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;

        // Fill to capacity, then overflow
        for (int i = 0; i < SIZE; i++) begin
            exp_wr(i, i);
            issue(1, i);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_depth", 32'(depth), SIZE);
        chk("fill_ovf_before", 32'(err_overflow), 0);
        issue(1, 16'hFFFF);
        chk("ovf_flag", 32'(err_overflow), 1);
        chk("ovf_depth", 32'(depth), SIZE);
        chk("ovf_tos", 32'(tos), 63);
        chk("ovf_nos", 32'(nos), 62);
        chk("ovf_udf", 32'(err_underflow), 0);

        // BIN / DUP / OVER / REPL
        do_reset();
        chk("rst2_flags", {30'd0, err_overflow, err_underflow}, 0);
        exp_wr(0, 5);  issue(1, 5);
        exp_wr(1, 7);  issue(1, 7);
        exp_wr(0, 12); issue(7, 12);
        chk("bin_depth", 32'(depth), 1);
        chk("bin_tos", 32'(tos), 12);
        chk("bin_nos", 32'(nos), 0);
        exp_wr(1, 12); issue(3, 0);
        chk("dup_depth", 32'(depth), 2);
        chk("dup_tos", 32'(tos), 12);
        chk("dup_nos", 32'(nos), 12);
        exp_wr(2, 12); issue(4, 0);
        chk("over_depth", 32'(depth), 3);
        chk("over_tos", 32'(tos), 12);
        exp_wr(2, 9);  issue(6, 9);
        chk("repl_tos", 32'(tos), 9);
        chk("repl_nos", 32'(nos), 12);
        chk("repl_depth", 32'(depth), 3);

        // DUP on empty is underflow; OVER at depth 1 is underflow
        do_reset();
        issue(3, 0);
        chk("dup_empty_udf", 32'(err_underflow), 1);
        chk("dup_empty_ovf", 32'(err_overflow), 0);
        chk("dup_empty_depth", 32'(depth), 0);
        do_reset();
        exp_wr(0, 16'h4444); issue(1, 16'h4444);
        issue(4, 0);
        chk("over_d1_udf", 32'(err_underflow), 1);
        chk("over_d1_depth", 32'(depth), 1);

        // Reset during SWAP2 drops the second write
        do_reset();
        exp_wr(0, 16'hAAAA); issue(1, 16'hAAAA);
        exp_wr(1, 16'hBBBB); issue(1, 16'hBBBB);
        exp_wr(1, 16'hAAAA); issue(5, 0);
        chk("mid_swap_ready", 32'(op_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_swap_we", 32'(mem_we), 0);
        chk("mid_swap_depth", 32'(depth), 0);
        chk("mid_swap_ready_rst", 32'(op_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_swap_mem0", 32'(mem[0]), 32'hAAAA);
        chk("mid_swap_post_ready", 32'(op_ready), 1);
        chk("pending_writes", 32'(wq.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Pointer and sequencing front-end for the 16-bit 2R/1W data stack memory; sits directly upstream of it and drives both async read addresses plus the single sync write port.
- Executes one stack operation per accepted request, exposes top-of-stack (tos) and next-on-stack (nos) combinationally, and reports depth and sticky overflow/underflow errors.
- SWAP needs two writes, so it takes two cycles through an internal FSM with a ready/valid handshake.

Parameters:
- WIDTH, 6, memory address width.
- SIZE, 64, stack capacity in entries; must equal 2**WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- op_valid  in  1  request present.
- op_ready  out  1  request accepted this cycle when op_valid is high.
- op  in  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 OVER, 5 SWAP, 6 REPL, 7 BIN.
- din  in  16  operand for PUSH, REPL and BIN.
- tos  out  16  top entry; 0 when depth<1.
- nos  out  16  second entry; 0 when depth<2.
- depth  out  WIDTH+1  entry count, 0..SIZE.
- empty  out  1  depth==0.
- full  out  1  depth==SIZE.
- err_overflow  out  1  sticky overflow flag.
- err_underflow  out  1  sticky underflow flag.
- err_clear  in  1  clears both sticky flags.
- mem_dout_addr0  out  WIDTH  read address 0, driven as (sp-1) mod SIZE.
- mem_dout0  in  16  read data 0.
- mem_dout_addr1  out  WIDTH  read address 1, driven as (sp-2) mod SIZE.
- mem_dout1  in  16  read data 1.
- mem_we  out  1  write enable.
- mem_din_addr  out  WIDTH  write address.
- mem_din  out  16  write data.

Behaviour:
- State: sp register (WIDTH+1 bits, equals depth), FSM {IDLE, SWAP2}, 16-bit swap latch, two sticky error flags.
- Reset values: sp=0, FSM=IDLE, flags=0, swap latch=0.
- Outputs during and after reset: depth=0, empty=1, full=0, op_ready=1. mem_we is forced to 0 combinationally whenever rst_n is low.
- Read path: tos and nos are combinational from mem_dout0/1, masked to 0 by depth.
- Handshake: op_ready is 1 only in IDLE. An operation is accepted when op_valid and op_ready are both high.
- Write timing: mem_we, mem_din_addr and mem_din are combinational in the accept cycle. The memory write and the sp update land on the same rising edge.
- Per-op effects (legal case):
  - NOP: nothing.
  - PUSH: write din at sp; sp+1.
  - POP: sp-1; no write.
  - DUP: write tos at sp; sp+1.
  - OVER: write nos at sp; sp+1.
  - REPL: write din at sp-1; sp unchanged.
  - BIN: write din at sp-2; sp-1. Consumes the two top entries and pushes the ALU result.
  - SWAP: cycle 1 writes nos at sp-1, latches tos, and goes to SWAP2. Cycle 2 writes the latch at sp-2, returns to IDLE, and holds op_ready=0.
- Legality rules:
  - Overflow: PUSH, DUP or OVER when full.
  - Underflow: depth<1 for POP, DUP, REPL; depth<2 for OVER, SWAP, BIN.
- Illegal op:
  - Still accepted (op_ready is not withheld).
  - No write, sp unchanged, FSM stays IDLE.
  - Sets the matching sticky flag.
  - DUP on an empty stack counts as underflow, not overflow.
- Error flags:
  - err_clear takes effect on the next edge.
  - A new error in the same cycle as err_clear wins, so the flag stays 1.
- Boundaries:
  - Addresses wrap mod SIZE, using the low WIDTH bits of the pointer arithmetic.
  - Read addresses wrap harmlessly when depth<2; the data is masked.
  - sp reaches SIZE exactly; full depth is representable.
- op_valid low in SWAP2 has no effect; the second write always completes unless reset.
- Reset mid-SWAP (in SWAP2): return to IDLE, drop the second write, sp=0.
- Memory write-through: no bypass is needed, because reads are async and the write lands at the edge. tos/nos reflect new contents the cycle after the edge.

Test Plan:
- Reset, then PUSH 0x1111, 0x2222, 0x3333 -> depth=3, tos=0x3333, nos=0x2222, writes at addresses 0,1,2.
- From [0x1111,0x2222], issue SWAP with op_valid held -> op_ready=0 for exactly one cycle; afterwards tos=0x1111, nos=0x2222, depth=2, two mem_we pulses at addresses 1 then 0.
- POP on empty -> err_underflow=1, depth=0, no mem_we. Assert err_clear -> flag 0 next cycle. Assert err_clear together with another POP -> flag stays 1.
- PUSH 64 values 0..63, then PUSH 0xFFFF -> full=1, depth=64, err_overflow=1, entry 63 intact, tos=63.
- From [5,7], BIN with din=12 -> depth=1, tos=12. Then DUP -> depth=2, tos=nos=12. Then OVER -> depth=3, tos=12. Then REPL with din=9 -> tos=9, depth=3.
- SWAP accepted at depth 2, rst_n pulsed low during SWAP2 -> depth=0, op_ready=1, mem_we=0 while rst_n is low, no second write.
